// File: rtl/efx_frame_scheduler.sv
// Per-frame scheduler that time-shares one multi-cycle MAC among NREQ requesters.
// Each frame starts on reset release (the codec LR clock going high). Requests are
// snapshotted once and each set bit is served once, lowest index first. The frame
// ends with a single frame_done pulse, and the scheduler then idles until the next reset.
module efx_frame_scheduler #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            CLOCK_50,
    input  logic            AUD_DACLRCK,
    input  logic [NREQ-1:0] req,
    input  logic            mac_done,
    output logic [NREQ-1:0] grant,
    output logic            mac_start,
    output logic            busy,
    output logic            frame_done,
    output logic            timeout_err
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StSync,
        StSnap,
        StArb,
        StIssue,
        StWait,
        StDone
    } state_e;

    state_e          state;
    logic [1:0]      rst_q;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] pick;
    logic [CW-1:0]   cnt;

    // Two-flop release synchroniser; assertion stays asynchronous.
    always_ff @(posedge CLOCK_50 or negedge AUD_DACLRCK) begin
        if (!AUD_DACLRCK) begin
            rst_q <= 2'b00;
        end else begin
            rst_q <= {rst_q[0], 1'b1};
        end
    end

    // Isolate the lowest set pending bit: this is the fixed-priority winner.
    always_comb begin
        pick = pending & (~pending + NREQ'(1));
    end

    // Scheduler FSM. All outputs are registered and take their value on state entry,
    // so cnt equals the number of cycles elapsed since mac_start.
    always_ff @(posedge CLOCK_50 or negedge AUD_DACLRCK) begin
        if (!AUD_DACLRCK) begin
            state       <= StSync;
            pending     <= '0;
            cnt         <= '0;
            grant       <= '0;
            mac_start   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            mac_start   <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state)
                StSync: begin
                    // Enter SNAP on the same edge that the chain fills to 2'b11.
                    if (rst_q == 2'b01) begin
                        state <= StSnap;
                        busy  <= 1'b1;
                    end
                end
                StSnap: begin
                    pending <= req;
                    state   <= StArb;
                end
                StArb: begin
                    if (pending == '0) begin
                        state      <= StDone;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        grant     <= pick;
                        mac_start <= 1'b1;
                        cnt       <= '0;
                        state     <= StIssue;
                    end
                end
                StIssue: begin
                    cnt   <= cnt + CW'(1);
                    state <= StWait;
                end
                StWait: begin
                    // mac_done takes priority over a timeout in the same cycle.
                    if (mac_done) begin
                        pending <= pending & ~grant;
                        grant   <= '0;
                        state   <= StArb;
                    end else if (cnt == CntLast) begin
                        pending     <= pending & ~grant;
                        grant       <= '0;
                        timeout_err <= 1'b1;
                        state       <= StArb;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                StDone: begin
                    state <= StDone;
                end
                default: begin
                    state <= StSync;
                end
            endcase
        end
    end

endmodule
